serial_frame_master: RTL
========================

SERIAL_FRAME_MASTER -- requirements
Module: serial_frame_master

Interface
REQ-001 SHALL have parameter DIV, default 5, sclk half-period in clk cycles, legal range 2..255.
REQ-002 SHALL have parameter NBITS, default 7, bits per frame, legal range 1..16.
REQ-003 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, frame request; sampled only in IDLE.
REQ-006 SHALL have port tx_data, input, NBITS, frame payload; latched on accepted start.
REQ-007 SHALL have port busy, output, 1, high from accepted start through the DONE cycle.
REQ-008 SHALL have port done, output, 1, one-cycle pulse at frame end.
REQ-009 SHALL have port rx_data, output, NBITS, bits captured from sout; held until next frame completes.
REQ-010 SHALL have ports sclk (idle 1), ce (active-low, idle 1) and sin, each output, 1, driving the serial slave.
REQ-011 SHALL have port sout, input, 1, serial slave output.

Function
REQ-012 SHALL implement states IDLE, SETUP, BIT_LO, BIT_HI, HOLD, DONE.
REQ-013 IDLE: ce=1, sclk=1, sin=0, busy=0; start=1 -> latch tx_data, bit index 0, go SETUP next cycle.
REQ-014 SETUP: ce=0, sclk=1 for DIV cycles -> BIT_LO.
REQ-015 BIT_LO: ce=0, sclk=0, sin=tx_data[index] (LSB first) for DIV cycles -> BIT_HI.
REQ-016 BIT_HI: sclk=1, sin held, for DIV cycles; on last BIT_HI cycle capture sout into rx shadow bit [index]; then index<NBITS-1 -> index+1, BIT_LO; else HOLD.
REQ-017 HOLD: ce=0, sclk=1 for 2*DIV cycles -> DONE.
REQ-018 DONE: ce=1, done=1, busy=1 for exactly one cycle; rx_data updates from shadow this cycle; -> IDLE.
REQ-019 Busy duration SHALL be (2*NBITS+3)*DIV+1 cycles (86 for defaults).
REQ-020 start while busy, including the DONE cycle, SHALL be ignored; no queuing.
REQ-021 tx_data changes after acceptance SHALL not affect the frame in progress.
REQ-022 Half-period counter SHALL reload on every state change; no sclk glitch at phase boundaries.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 reset SHALL asynchronously force IDLE, ce=1, sclk=1, sin=0, busy=0, done=0, rx_data=0, counters 0.
REQ-025 Reset mid-frame SHALL abort it without a done pulse; first start after release begins a fresh frame.

Configuration
REQ-026 With SFM_RX_CAPTURE_EN defined, REQ-016 and REQ-018 capture SHALL be implemented.
REQ-027 Without SFM_RX_CAPTURE_EN, rx_data SHALL be constant 0, sout unused, and no shadow register synthesized; all other timing identical.

Structure
REQ-028 Package sfm_pkg SHALL hold the state enum, DIV/NBITS defaults, and counter width constant.
REQ-029 Half-period tick counter SHALL be a sub-module sfm_halfdiv (load, tick output).

Verification
REQ-030 Reset: assert reset 3 cycles mid-BIT_LO -> ce=1, sclk=1, busy=0 immediately; no done.
REQ-031 Defaults, tx_data=7'b1101001, start 1 cycle -> sin sequence 1,0,0,1,0,1,1 across 7 sclk lows; each sclk phase 5 cycles; busy 86 cycles; one done.
REQ-032 sout model = slave shift register echoing sin one frame late; second frame with tx_data=7'h00 -> rx_data=7'b1101001 at done.
REQ-033 start held high continuously -> frames back-to-back with exactly one IDLE cycle between; done count equals frame count.
REQ-034 start pulsed during BIT_HI of bit 3 -> ignored; tx_data change mid-frame -> no effect on sin.
REQ-035 DIV=2, NBITS=1 -> busy 11 cycles, single sclk low pulse of 2 cycles.

Source files
------------

// File: rtl/sfm_pkg.sv
// ----------------------------------------------------------------------------
// sfm_pkg
// Shared types and constants for the serial frame master.
//   sfm_state_t   : frame sequencer states
//   DIV_DEFAULT   : default sclk half-period in clk cycles
//   NBITS_DEFAULT : default bits per frame
//   CNT_W         : width of the half-period counter
// ----------------------------------------------------------------------------
package sfm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        BIT_LO = 3'd2,
        BIT_HI = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } sfm_state_t;

    localparam int DIV_DEFAULT   = 5;
    localparam int NBITS_DEFAULT = 7;

    // HOLD lasts two half-periods, so the counter must hold 2*DIV-1 = 509
    // for the largest DIV of 255.
    localparam int CNT_W = 9;

endpackage

// File: rtl/sfm_halfdiv.sv
// ----------------------------------------------------------------------------
// sfm_halfdiv
// Reloadable down-counter that times each sequencer phase.
//   clk      : system clock
//   reset    : asynchronous active-high reset, counter cleared to 0
//   load     : reload the counter with load_val this cycle
//   load_val : number of cycles in the new phase minus one
//   tick     : high during the last cycle of the current phase (count == 0)
// ----------------------------------------------------------------------------
module sfm_halfdiv
    import sfm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/serial_frame_master.sv
// ----------------------------------------------------------------------------
// serial_frame_master
// Clocks one NBITS-bit frame out to a serial slave (LSB first on sin) while
// optionally capturing the slave's reply from sout.
//
// Handshake: start is looked at only while the block is idle (busy low). A
// start seen high in IDLE is accepted on that clock edge: tx_data is latched
// and busy rises the next cycle. busy stays high through the single-cycle
// done pulse; any start while busy (including the done cycle) is dropped.
//
// Parameters
//   DIV   : sclk half-period in clk cycles (2..255)
//   NBITS : bits per frame (1..16)
// Ports
//   clk, reset      : system clock, asynchronous active-high reset
//   start, tx_data  : frame request and payload
//   busy, done      : frame in progress, one-cycle end-of-frame pulse
//   rx_data         : bits captured from sout, updated in the done cycle
//   sclk, ce, sin   : serial clock (idle 1), active-low enable, serial data
//   sout            : serial data from the slave
//   state           : current sequencer state, for observation
// Build option
//   SFM_RX_CAPTURE_EN : when defined, sout is sampled into rx_data; when
//                       undefined rx_data is tied to 0 and sout is ignored.
// ----------------------------------------------------------------------------
module serial_frame_master
    import sfm_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NBITS-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] rx_data,
    output logic             sclk,
    output logic             ce,
    output logic             sin,
    input  logic             sout,
    output sfm_state_t       state
);

    localparam int               IDX_W     = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBITS - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(2 * DIV - 1);

    sfm_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NBITS-1:0] tx_q;
    logic             accept;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             tick;

    sfm_halfdiv u_halfdiv (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tick     (tick)
    );

    // Next-state logic. Every state change reloads the phase counter, so
    // each phase starts with a full count regardless of where it came from.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        accept   = 1'b0;
        load     = 1'b0;
        load_val = HALF_LOAD;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_d = BIT_LO;
            end
            BIT_LO: begin
                if (tick) state_d = BIT_HI;
            end
            BIT_HI: begin
                if (tick) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = BIT_LO;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        load = (state_d != state_q);
        if (state_d == HOLD) load_val = HOLD_LOAD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) tx_q <= tx_data;
        end
    end

    // Outputs are registered from the next state so they line up exactly
    // with state_q and change only on clock edges (no sclk glitches).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            sclk <= 1'b1;
            ce   <= 1'b1;
            sin  <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            done <= (state_d == DONE);
            sclk <= (state_d != BIT_LO);
            ce   <= (state_d == IDLE) || (state_d == DONE);
            sin  <= ((state_d == BIT_LO) || (state_d == BIT_HI)) ? tx_q[idx_d] : 1'b0;
        end
    end

    assign state = state_q;

`ifdef SFM_RX_CAPTURE_EN
    logic [NBITS-1:0] shadow;
    logic [NBITS-1:0] rx_q;

    // sout is sampled at the end of the high phase, after the slave has had
    // a full half-period to drive it following the sclk rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
            rx_q   <= '0;
        end else begin
            if ((state_q == BIT_HI) && tick) shadow[idx_q] <= sout;
            if (state_d == DONE) rx_q <= shadow;
        end
    end

    assign rx_data = rx_q;
`else
    logic unused_sout;
    assign unused_sout = sout;
    assign rx_data     = '0;
`endif

endmodule
